// File: rtl/mgpio_nasti_pkg.sv
// rtl/mgpio_nasti_pkg.sv - shared types and helpers for the mgpio NASTI-lite 32-to-8 downsizer
package mgpio_nasti_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam int LANES = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    B_OUT,
    R_OUT
  } state_t;

  // Lowest enabled strobe lane strictly above cur; result is {found, lane}.
  function automatic logic [2:0] next_lane(input logic [3:0] strb, input logic [1:0] cur);
    logic [2:0] res;
    res = 3'b000;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (strb[i] && (i > int'(cur))) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mgpio_nasti_downsizer.sv
// rtl/mgpio_nasti_downsizer.sv - splits 32-bit NASTI-lite transactions into serial byte beats
module mgpio_nasti_downsizer
  import mgpio_nasti_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [2:0]            s_awprot,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [2:0]            s_arprot,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [7:0]            m_wdata,
  output logic                  m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [7:0]            m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   base;
  logic [2:0]              prot;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic [1:0]              lane;
  resp_t                   acc;
  logic [31:0]             rdata;
  logic                    wr_acc, rd_acc;
  logic [2:0]              first_lane, nxt;

  // Write wins when both address channels are pending in the same cycle.
  assign wr_acc     = (state == IDLE) && s_awvalid && s_wvalid;
  assign rd_acc     = (state == IDLE) && !(s_awvalid && s_wvalid) && s_arvalid;
  assign first_lane = s_wstrb[0] ? 3'b100 : next_lane(s_wstrb, 2'd0);
  assign nxt        = next_lane(wstrb, lane);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (wr_acc) begin
          state_nx = first_lane[2] ? WR_REQ : B_OUT;
        end else if (rd_acc) begin
          state_nx = RD_REQ;
        end
      end
      WR_REQ:  if (m_awready && m_wready) state_nx = WR_RESP;
      WR_RESP: if (m_bvalid) state_nx = nxt[2] ? WR_REQ : B_OUT;
      RD_REQ:  if (m_arready) state_nx = RD_RESP;
      RD_RESP: if (m_rvalid) state_nx = (lane == 2'd3) ? R_OUT : RD_REQ;
      B_OUT:   if (s_bready) state_nx = IDLE;
      R_OUT:   if (s_rready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base  <= '0;
      prot  <= '0;
      wdata <= '0;
      wstrb <= '0;
      lane  <= '0;
      acc   <= RESP_OKAY;
      rdata <= '0;
    end else begin
      if (wr_acc) begin
        base  <= s_awaddr & ADDR_MASK;
        prot  <= s_awprot;
        wdata <= s_wdata;
        wstrb <= s_wstrb;
        lane  <= first_lane[1:0];
        acc   <= RESP_OKAY;
      end else if (rd_acc) begin
        base  <= s_araddr & ADDR_MASK;
        prot  <= s_arprot;
        lane  <= 2'd0;
        acc   <= RESP_OKAY;
      end
      if ((state == WR_RESP) && m_bvalid) begin
        acc <= acc | m_bresp;
        if (nxt[2]) lane <= nxt[1:0];
      end
      // Error beats still deliver their byte; the merged response carries the error.
      if ((state == RD_RESP) && m_rvalid) begin
        rdata[{lane, 3'b000} +: 8] <= m_rdata;
        acc                        <= acc | m_rresp;
        lane                       <= lane + 2'd1;
      end
    end
  end

  always_comb begin
    s_awready = wr_acc;
    s_wready  = wr_acc;
    s_arready = rd_acc;
    s_bvalid  = (state == B_OUT);
    s_bresp   = (state == B_OUT) ? acc : RESP_OKAY;
    s_rvalid  = (state == R_OUT);
    s_rresp   = (state == R_OUT) ? acc : RESP_OKAY;
    s_rdata   = rdata;
    m_awaddr  = base | ADDR_WIDTH'(lane);
    m_araddr  = base | ADDR_WIDTH'(lane);
    m_awprot  = prot;
    m_arprot  = prot;
    m_awvalid = (state == WR_REQ);
    m_wvalid  = (state == WR_REQ);
    m_wstrb   = (state == WR_REQ);
    m_wdata   = wdata[{lane, 3'b000} +: 8];
    m_bready  = (state == WR_RESP);
    m_arvalid = (state == RD_REQ);
    m_rready  = (state == RD_RESP);
  end

endmodule

// File: tb/tb_mgpio_nasti_downsizer.sv
// tb/tb_mgpio_nasti_downsizer.sv - self-checking bench for the NASTI-lite downsizer
module tb_mgpio_nasti_downsizer;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [2:0] s_awprot, s_arprot, m_awprot, m_arprot;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0] s_wstrb;
  logic [1:0] s_bresp, s_rresp, m_bresp, m_rresp;
  logic m_awvalid, m_awready, m_wstrb, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [7:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  mgpio_nasti_downsizer #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } beat_t;

  typedef struct {
    bit                  rd;
    logic [AW-1:0]       a;
    logic [31:0]         d;
    logic [3:0]          st;
    logic [AW-1:0]       ea;
    logic [1:0]          ec;
    logic [1:0]          xresp;
    logic [31:0]         xrdata;
    int                  xn;
    logic [3:0][AW-1:0]  xaddr;
    logic [3:0][7:0]     xbyte;
  } vec_t;

  beat_t wq[$];
  beat_t rq[$];
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] err_addr;
  logic [1:0] err_code;
  bit stall_en;
  int n_tests, n_fail, wstrb_bad;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Downstream byte slave: optional ready stalls, one-cycle response, error on err_addr.
  initial begin
    bit w_pend, r_pend, b_fire, r_fire, rdy;
    logic [AW-1:0] w_a, r_a;
    w_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0; w_a = '0; r_a = '0;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
        w_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
        continue;
      end
      if (b_fire) m_bvalid = 0;
      if (r_fire) m_rvalid = 0;
      if (w_pend) begin
        m_bvalid = 1; m_bresp = (w_a == err_addr) ? err_code : 2'b00; w_pend = 0;
      end
      if (r_pend) begin
        m_rvalid = 1; m_rdata = mem[r_a]; m_rresp = (r_a == err_addr) ? err_code : 2'b00;
        r_pend = 0;
      end
      rdy = !stall_en || ($urandom_range(0, 2) != 0);
      m_awready = rdy; m_wready = rdy;
      m_arready = !stall_en || ($urandom_range(0, 2) != 0);
      if (m_awvalid && m_wvalid && m_awready && m_wready) begin
        wq.push_back('{m_awaddr, m_wdata});
        if (m_wstrb !== 1'b1) wstrb_bad++;
        mem[m_awaddr] = m_wdata; w_pend = 1; w_a = m_awaddr;
      end
      if (m_arvalid && m_arready) begin
        rq.push_back('{m_araddr, 8'h00}); r_pend = 1; r_a = m_araddr;
      end
      b_fire = m_bvalid && m_bready;
      r_fire = m_rvalid && m_rready;
    end
  end

  task automatic send_aw_w(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] st);
    int n = 0;
    @(negedge clk);
    s_awaddr = a; s_awprot = 3'b010; s_wdata = d; s_wstrb = st; s_awvalid = 1; s_wvalid = 1;
    #1;
    while (!s_awready && n < 100) begin @(negedge clk); #1; n++; end
    chk("aw_accept", {s_awready, s_wready}, 2'b11);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    int n = 0;
    @(negedge clk);
    s_araddr = a; s_arprot = 3'b001; s_arvalid = 1;
    #1;
    while (!s_arready && n < 100) begin @(negedge clk); #1; n++; end
    chk("ar_accept", s_arready, 1);
    @(negedge clk);
    s_arvalid = 0;
  endtask

  task automatic get_b(input int dly, output logic [1:0] resp);
    int n = 0;
    bit stable = 1;
    logic [1:0] r0;
    #1;
    while (!s_bvalid && n < 200) begin @(negedge clk); #1; n++; end
    chk("b_arrive", s_bvalid, 1);
    r0 = s_bresp;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk); #1;
      if (!s_bvalid || s_bresp !== r0) stable = 0;
    end
    if (dly > 0) chk("b_stable", stable, 1);
    s_bready = 1; resp = r0;
    @(negedge clk);
    s_bready = 0;
  endtask

  task automatic get_r(input int dly, output logic [1:0] resp, output logic [31:0] data);
    int n = 0;
    bit stable = 1;
    #1;
    while (!s_rvalid && n < 200) begin @(negedge clk); #1; n++; end
    chk("r_arrive", s_rvalid, 1);
    resp = s_rresp; data = s_rdata;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk); #1;
      if (!s_rvalid || s_rresp !== resp || s_rdata !== data) stable = 0;
    end
    if (dly > 0) chk("r_stable", stable, 1);
    s_rready = 1;
    @(negedge clk);
    s_rready = 0;
  endtask

  task automatic do_txn(input bit rd, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] st, input int dly,
                        output logic [1:0] resp, output logic [31:0] rdata);
    wq.delete(); rq.delete();
    rdata = '0;
    if (rd) begin
      send_ar(a); get_r(dly, resp, rdata);
    end else begin
      send_aw_w(a, d, st); get_b(dly, resp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp, xresp, r0;
    logic [31:0] rdata, xrdata, d;
    logic [AW-1:0] a, base;
    logic [3:0] st;
    logic [3:0][AW-1:0] xaddr;
    logic [3:0][7:0] xbyte;
    int nb, xn, lat, viol, n, dly;
    bit rd;

    n_tests = 0; n_fail = 0; wstrb_bad = 0;
    rst = 1; stall_en = 0; err_addr = '0; err_code = 2'b00;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 8'($urandom); ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[13'h020 + i] = 8'hAA + 8'(i * 17); ref_mem[13'h020 + i] = mem[13'h020 + i];
      mem[13'h030 + i] = 8'h01 + 8'(i);      ref_mem[13'h030 + i] = mem[13'h030 + i];
    end

    vecs[0] = '{0, 13'h010, 32'h44332211, 4'hF, 13'h0, 2'b00, 2'b00, 32'h0, 4,
                {13'h013, 13'h012, 13'h011, 13'h010}, {8'h44, 8'h33, 8'h22, 8'h11}};
    vecs[1] = '{0, 13'h013, 32'h44332211, 4'b0101, 13'h0, 2'b00, 2'b00, 32'h0, 2,
                {13'h0, 13'h0, 13'h012, 13'h010}, {8'h0, 8'h0, 8'h33, 8'h11}};
    vecs[2] = '{0, 13'h014, 32'h99887766, 4'h0, 13'h0, 2'b00, 2'b00, 32'h0, 0,
                {13'h0, 13'h0, 13'h0, 13'h0}, {8'h0, 8'h0, 8'h0, 8'h0}};
    vecs[3] = '{1, 13'h020, 32'h0, 4'h0, 13'h0, 2'b00, 2'b00, 32'hDDCCBBAA, 4,
                {13'h023, 13'h022, 13'h021, 13'h020}, {8'h0, 8'h0, 8'h0, 8'h0}};
    vecs[4] = '{1, 13'h031, 32'h0, 4'h0, 13'h032, 2'b11, 2'b11, 32'h04030201, 4,
                {13'h033, 13'h032, 13'h031, 13'h030}, {8'h0, 8'h0, 8'h0, 8'h0}};
    vecs[5] = '{0, 13'h040, 32'hA5B6C7D8, 4'b1010, 13'h043, 2'b10, 2'b10, 32'h0, 2,
                {13'h0, 13'h0, 13'h043, 13'h041}, {8'h0, 8'h0, 8'hA5, 8'hC7}};
    vecs[6] = '{0, 13'h052, 32'h12345678, 4'b0110, 13'h051, 2'b01, 2'b01, 32'h0, 2,
                {13'h0, 13'h0, 13'h052, 13'h051}, {8'h0, 8'h0, 8'h34, 8'h56}};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_handshakes", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 10'b0);
    chk("rst_rdata", s_rdata, 32'h0);
    chk("rst_resp", {s_bresp, s_rresp}, 4'h0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 7; i++) begin
      err_addr = vecs[i].ea; err_code = vecs[i].ec;
      do_txn(vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].st, 0, resp, rdata);
      nb = vecs[i].rd ? rq.size() : wq.size();
      chk($sformatf("vec%0d_resp", i), resp, vecs[i].xresp);
      chk($sformatf("vec%0d_nbeat", i), nb, vecs[i].xn);
      for (int j = 0; j < vecs[i].xn && j < nb; j++) begin
        if (vecs[i].rd) begin
          chk($sformatf("vec%0d_raddr%0d", i, j), rq[j].a, vecs[i].xaddr[j]);
        end else begin
          chk($sformatf("vec%0d_waddr%0d", i, j), wq[j].a, vecs[i].xaddr[j]);
          chk($sformatf("vec%0d_wdata%0d", i, j), wq[j].d, vecs[i].xbyte[j]);
          ref_mem[vecs[i].xaddr[j]] = vecs[i].xbyte[j];
        end
      end
      if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].xrdata);
    end
    err_code = 2'b00;

    // Full read latency with no backpressure anywhere.
    @(negedge clk);
    s_araddr = 13'h020; s_arvalid = 1; s_rready = 1; lat = 1;
    #1;
    chk("lat_ar_accept", s_arready, 1);
    @(negedge clk);
    s_arvalid = 0;
    #1;
    while (!s_rvalid && lat < 40) begin @(negedge clk); #1; lat++; end
    chk("lat_read_cycles", lat + 1, 10);
    chk("lat_read_data", s_rdata, 32'hDDCCBBAA);
    @(negedge clk);
    s_rready = 0;

    // Simultaneous write and read requests: the write must finish first.
    wq.delete();
    @(negedge clk);
    s_awaddr = 13'h060; s_wdata = 32'h0A0B0C0D; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    s_araddr = 13'h060; s_arvalid = 1;
    #1;
    chk("t5_write_wins", {s_awready, s_wready, s_arready}, 3'b110);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0; viol = 0; n = 0;
    #1;
    while (!s_bvalid && n < 100) begin
      if (s_arready) viol++;
      @(negedge clk); #1; n++;
    end
    if (s_arready) viol++;
    chk("t5_bresp", {s_bvalid, s_bresp}, 3'b100);
    s_bready = 1;
    @(negedge clk);
    s_bready = 0;
    #1;
    chk("t5_no_early_ar", viol, 0);
    chk("t5_ar_after_b", s_arready, 1);
    chk("t5_nbeat", wq.size(), 4);
    for (int i = 0; i < 4; i++) ref_mem[13'h060 + i] = 8'(32'h0A0B0C0D >> (8 * i));
    @(negedge clk);
    s_arvalid = 0;
    get_r(0, resp, rdata);
    chk("t5_rdata", rdata, 32'h0A0B0C0D);

    // Upstream response held under s_bready backpressure.
    wq.delete();
    err_addr = 13'h071; err_code = 2'b10;
    send_aw_w(13'h070, 32'hCAFEF00D, 4'hF);
    #1; n = 0;
    while (!s_bvalid && n < 100) begin @(negedge clk); #1; n++; end
    r0 = s_bresp;
    chk("t6_bresp", {s_bvalid, r0}, 3'b110);
    s_awaddr = 13'h080; s_awvalid = 1; s_wvalid = 1; s_araddr = 13'h080; s_arvalid = 1; viol = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (!s_bvalid || s_bresp !== 2'b10 || s_awready || s_wready || s_arready) viol++;
    end
    chk("t6_stall_stable", viol, 0);
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    get_b(0, resp);
    chk("t6_bresp_final", resp, 2'b10);
    chk("t6_nbeat", wq.size(), 4);
    for (int i = 0; i < 4; i++) ref_mem[13'h070 + i] = 8'(32'hCAFEF00D >> (8 * i));
    err_code = 2'b00;

    // Reset while waiting for a downstream read byte.
    @(negedge clk);
    s_araddr = 13'h020; s_arvalid = 1;
    #1;
    @(negedge clk);
    s_arvalid = 0; n = 0;
    #1;
    while (!m_rready && n < 20) begin @(negedge clk); #1; n++; end
    chk("t6_in_rd_resp", m_rready, 1);
    rst = 1;
    @(negedge clk);
    #1;
    chk("t6_rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
        s_bvalid, s_rvalid, s_awready, s_arready}, 9'b0);
    chk("t6_rst_rdata", s_rdata, 32'h0);
    @(negedge clk);
    rst = 0;
    do_txn(1, 13'h030, 32'h0, 4'h0, 0, resp, rdata);
    chk("t6_recover_rdata", rdata, 32'h04030201);
    chk("t6_recover_resp", resp, 2'b00);

    // Randomized traffic against a byte-memory reference model.
    for (int t = 0; t < 60; t++) begin
      rd = 1'($urandom_range(0, 1));
      a = 13'h100 + 13'($urandom_range(0, 63));
      d = $urandom;
      st = 4'($urandom);
      dly = $urandom_range(0, 3);
      stall_en = 1'($urandom_range(0, 1));
      base = a & ~13'd3;
      if ($urandom_range(0, 2) == 0) begin
        err_addr = base + 13'($urandom_range(0, 3));
        err_code = 2'($urandom_range(1, 3));
      end else begin
        err_code = 2'b00;
      end
      xresp = 2'b00; xn = 0; xrdata = '0; xaddr = '0; xbyte = '0;
      for (int l = 0; l < 4; l++) begin
        if (rd || st[l]) begin
          xaddr[xn] = base + 13'(l);
          if (xaddr[xn] == err_addr) xresp = xresp | err_code;
          if (rd) begin
            xrdata[8 * l +: 8] = ref_mem[xaddr[xn]];
          end else begin
            xbyte[xn] = d[8 * l +: 8];
            ref_mem[xaddr[xn]] = xbyte[xn];
          end
          xn++;
        end
      end
      do_txn(rd, a, d, st, dly, resp, rdata);
      nb = rd ? rq.size() : wq.size();
      chk($sformatf("rnd%0d_resp", t), resp, xresp);
      chk($sformatf("rnd%0d_nbeat", t), nb, xn);
      for (int j = 0; j < xn && j < nb; j++) begin
        if (rd) begin
          chk($sformatf("rnd%0d_raddr%0d", t, j), rq[j].a, xaddr[j]);
        end else begin
          chk($sformatf("rnd%0d_waddr%0d", t, j), wq[j].a, xaddr[j]);
          chk($sformatf("rnd%0d_wdata%0d", t, j), wq[j].d, xbyte[j]);
        end
      end
      if (rd) chk($sformatf("rnd%0d_rdata", t), rdata, xrdata);
    end

    chk("m_wstrb_one", wstrb_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
